fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side master for a standard-mode (non-FWFT) synchronous FIFO. Issues pops
//  on the FIFO read port and captures the returned words in a small credit-managed
//  output buffer. Presents them downstream on a valid/ready stream. Sits between
//  each switch ingress FIFO and the forwarding/arbiter logic.
// PARAMETERS
//  DATA_WIDTH     16  width of FIFO word and stream data
//  BUFFER_DEPTH   4   output buffer entries; power of two, >= 2
//  READ_LATENCY   1   cycles from fifo_read_enable to fifo_read_data_valid (1 or 2)
// PORTS
//  clock                input   1           single clock, rising edge
//  reset                input   1           async assert, active-high
//  enable               input   1           1 = may issue new pops; 0 = drain only
//  fifo_empty           input   1           FIFO empty flag
//  fifo_read_data       input   DATA_WIDTH  FIFO read data
//  fifo_read_data_valid input   1           FIFO read data qualifier
//  fifo_read_enable     output  1           pop request to FIFO
//  out_data             output  DATA_WIDTH  stream data (head of buffer)
//  out_valid            output  1           stream valid
//  out_ready            input   1           stream ready
//  word_count           output  32          words delivered downstream, wraps
//  protocol_error       output  1           sticky: unsolicited FIFO data or buffer overrun
// BEHAVIOUR
//  Reset (async, active-high): all outputs 0, buffer pointers 0, occupancy 0, in_flight 0.
//   - Reset mid-transfer discards buffered and in-flight words.
//   - Data returned after reset release with in_flight=0 sets protocol_error.
//  State:
//   - occupancy: 0..BUFFER_DEPTH
//   - in_flight: 0..READ_LATENCY*... (pops issued, data not yet returned)
//   - rd_ptr, wr_ptr: log2(BUFFER_DEPTH) bits, wrap naturally
//  fifo_read_enable = enable & !fifo_empty & (occupancy + in_flight < BUFFER_DEPTH)
//   - Uses registered occupancy/in_flight only; no combinational path from out_ready.
//  Push: fifo_read_data_valid=1 writes fifo_read_data at wr_ptr; wr_ptr++, in_flight--.
//  Pop: out_valid & out_ready; rd_ptr++, word_count++ (wraps 2^32-1 -> 0).
//  out_valid = (occupancy != 0)
//   - out_data = buf[rd_ptr], driven from registers.
//   - out_data held stable while out_valid & !out_ready.
//  Simultaneous push and pop: occupancy unchanged; both pointers advance.
//  Simultaneous issue and return: in_flight unchanged.
//  Empty buffer: a push is visible on out_valid the cycle after fifo_read_data_valid.
//   - No bypass.
//   - Minimum FIFO-to-stream latency is READ_LATENCY+1 cycles.
//  Throughput: sustained 1 word/cycle when BUFFER_DEPTH >= READ_LATENCY+2.
//   - Otherwise throughput is credit-limited; no loss either way.
//  enable deassert: no new pops; in-flight words still land; buffer still drains.
//  protocol_error set, sticky until reset, when either:
//   - fifo_read_data_valid=1 with in_flight=0, or
//   - a push arrives with occupancy=BUFFER_DEPTH and no same-cycle pop.
//   The offending word is dropped.
// TESTING
//  1. FIFO preloaded 0x0001..0x0010, out_ready=1 -> 16 words in order.
//     - Back-to-back after first at cycle READ_LATENCY+1; word_count=16.
//  2. 8 words queued, out_ready=0 -> fifo_read_enable stops after 4 pops.
//     - out_data=0x0001 held; release -> 8 words, none lost or duplicated.
//  3. out_ready toggled 1010..., FIFO writes every 3rd cycle, 100 words.
//     - Exact in-order match with scoreboard; protocol_error=0.
//  4. enable dropped one cycle after a pop issued:
//     - that word is still delivered; no further fifo_read_enable until enable=1.
//  5. reset pulsed with 3 words buffered, 1 in flight:
//     - out_valid=0, word_count=0 immediately; returning word sets protocol_error=1.
//  6. word_count preset near wrap (force 0xFFFFFFFE), 3 pops -> 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side master for a standard-mode FIFO feeding a valid/ready stream
//
// Pops words from a non-FWFT synchronous FIFO and holds them in a small
// credit-managed buffer. The buffer head is presented downstream as a stream.
// A pop is issued only when a buffer slot is reserved for its data. That covers
// both occupied slots and words still in the FIFO read pipeline. As a result the
// buffer cannot overrun unless the FIFO misbehaves.
//
// Ports
//   clock                 single clock, rising edge
//   reset                 asynchronous, active-high
//   enable                1 = new pops may be issued, 0 = drain only
//   fifo_empty            FIFO empty flag
//   fifo_read_data        FIFO read data
//   fifo_read_data_valid  qualifier for fifo_read_data
//   fifo_read_enable      pop request to the FIFO
//   out_data              stream data (buffer head, from registers)
//   out_valid             stream valid
//   out_ready             stream ready
//   word_count            words delivered downstream, wraps at 2^32
//   protocol_error        sticky: unsolicited FIFO data or buffer overrun

module fifo_stream_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_read_data_valid,
  output logic                  fifo_read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           word_count,
  output logic                  protocol_error
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(BUFFER_DEPTH);

  // Elaboration-time parameter sanity checks.
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("fifo_stream_reader: READ_LATENCY must be 1 or 2");
  end
  if (BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_stream_reader: BUFFER_DEPTH must be a power of two >= 2");
  end

  // Buffer storage and bookkeeping.
  logic [DATA_WIDTH-1:0] data_buf [BUFFER_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      occupancy;
  logic [CNT_W-1:0]      in_flight;

  // Handshake and event terms.
  logic [CNT_W:0] credits_used;
  logic           issue;
  logic           pop;
  logic           ret_ok;
  logic           unsolicited;
  logic           overrun;
  logic           push;

  // Credit check uses only registered state. out_ready has no path into the
  // FIFO read port; a slot freed by a pop is reused one cycle later.
  assign credits_used = {1'b0, occupancy} + {1'b0, in_flight};
  assign issue        = enable & ~fifo_empty & (credits_used < DEPTH_SUM);

  // Keep the pop request low while reset is held, even if enable is high.
  assign fifo_read_enable = issue & ~reset;

  assign out_valid = (occupancy != '0);
  assign out_data  = data_buf[rd_ptr];
  assign pop       = out_valid & out_ready;

  // A return counts against in_flight only when one was outstanding. A return
  // into a full buffer is dropped unless the head leaves in the same cycle.
  assign ret_ok      = fifo_read_data_valid & (in_flight != '0);
  assign unsolicited = fifo_read_data_valid & (in_flight == '0);
  assign overrun     = ret_ok & (occupancy == DEPTH_CNT) & ~pop;
  assign push        = ret_ok & ~overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      occupancy      <= '0;
      in_flight      <= '0;
      word_count     <= '0;
      protocol_error <= 1'b0;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        data_buf[i] <= '0;
      end
    end else begin
      if (push) begin
        data_buf[wr_ptr] <= fifo_read_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        word_count <= word_count + 32'd1;
      end

      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase

      case ({fifo_read_enable, ret_ok})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase

      if (unsolicited || overrun) begin
        protocol_error <= 1'b1;
      end
    end
  end

endmodule
